// File: rtl/airlock_cycle_ctrl.sv
// Airlock cycle controller. Sequences departure or arrival door cycles with pressure
// equalisation, dwell-qualified door closing, equalisation timeout and abort-to-restore.
module airlock_cycle_ctrl #(
    parameter int PW       = 8,
    parameter int P_LOW    = 10,
    parameter int P_HI_MIN = 90,
    parameter int P_HI_MAX = 110,
    parameter int DWELL    = 5,
    parameter int TIMEOUT  = 1024,
    parameter int CW       = 11
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic          abort,
    input  logic          odClosed,
    input  logic          idClosed,
    input  logic [PW-1:0] pressure,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic          startPressurizing,
    output logic          startDepressurizing,
    output logic [3:0]    state
);
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        PREP       = 4'd1,
        EQ1        = 4'd2,
        NEAR_OPEN  = 4'd3,
        NEAR_CLOSE = 4'd4,
        EQ2        = 4'd5,
        FAR_OPEN   = 4'd6,
        FAR_CLOSE  = 4'd7,
        RESTORE    = 4'd8,
        FAULT      = 4'd9
    } state_t;

    localparam logic [PW-1:0] LOW_T      = PW'(P_LOW);
    localparam logic [PW-1:0] HI_MIN_T   = PW'(P_HI_MIN);
    localparam logic [PW-1:0] HI_MAX_T   = PW'(P_HI_MAX);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    state_t        st_q, st_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          aborted_q, aborted_d;
    logic          pend_q, pend_d;
    logic          busy_d, done_d, fault_d;
    logic [1:0]    pump_d;
    logic          cnt_en, cnt_zero, reenter;

    logic is_low, is_high, above_band, doors_closed;
    logic near_closed, far_closed, at_near, at_far;
    logic timed, take_abort;

    assign is_low       = pressure < LOW_T;
    assign is_high      = (pressure > HI_MIN_T) && (pressure < HI_MAX_T);
    assign above_band   = pressure >= HI_MAX_T;
    assign doors_closed = odClosed & idClosed;
    assign near_closed  = mode_q ? odClosed : idClosed;
    assign far_closed   = mode_q ? idClosed : odClosed;
    assign at_near      = mode_q ? is_low : is_high;
    assign at_far       = mode_q ? is_high : is_low;
    assign timed        = (st_q == EQ1) || (st_q == EQ2) || (st_q == RESTORE);
    // An aborted restore is not re-entered, so a held abort cannot starve the timeout.
    assign take_abort   = (abort | pend_q) & doors_closed & ~((st_q == RESTORE) & aborted_q);
    assign state        = st_q;

    // {press, depress}: toward high pumps out only when above the band.
    function automatic logic [1:0] pump_dir(input logic to_high, input logic above);
        if (to_high && !above) pump_dir = 2'b10;
        else                   pump_dir = 2'b01;
    endfunction

    always_comb begin
        st_d      = st_q;
        mode_d    = mode_q;
        busy_d    = busy;
        done_d    = 1'b0;
        fault_d   = fault;
        pump_d    = {startPressurizing, startDepressurizing};
        aborted_d = aborted_q;
        pend_d    = pend_q;
        cnt_en    = 1'b0;
        cnt_zero  = 1'b0;
        reenter   = 1'b0;
        cnt_d     = cnt_q;
        case (st_q)
            IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    mode_d    = mode;
                    aborted_d = 1'b0;
                    pend_d    = 1'b0;
                    st_d      = PREP;
                end
            end
            FAULT: begin
                pump_d = 2'b00;
                if (abort && doors_closed) begin
                    fault_d = 1'b0;
                    busy_d  = 1'b0;
                    st_d    = IDLE;
                end
            end
            default: begin
                if (timed && cnt_q == TO_LAST) begin
                    pump_d  = 2'b00;
                    fault_d = 1'b1;
                    pend_d  = 1'b0;
                    st_d    = FAULT;
                end else if (take_abort) begin
                    pump_d    = 2'b00;
                    aborted_d = 1'b1;
                    pend_d    = 1'b0;
                    st_d      = RESTORE;
                    reenter   = 1'b1;
                end else begin
                    if (abort && !doors_closed) pend_d = 1'b1;
                    case (st_q)
                        PREP: begin
                            if (doors_closed) begin
                                if (at_near) st_d = NEAR_OPEN;
                                else begin
                                    st_d   = EQ1;
                                    pump_d = pump_dir(!mode_q, above_band);
                                end
                            end
                        end
                        EQ1: begin
                            cnt_en = 1'b1;
                            if (at_near) begin
                                pump_d = 2'b00;
                                st_d   = NEAR_OPEN;
                            end else pump_d = pump_dir(!mode_q, above_band);
                        end
                        NEAR_OPEN: begin
                            if (!near_closed) begin
                                cnt_en = 1'b1;
                                if (cnt_q == DWELL_LAST) st_d = NEAR_CLOSE;
                            end else cnt_zero = 1'b1;
                        end
                        NEAR_CLOSE: begin
                            if (near_closed) begin
                                st_d   = EQ2;
                                pump_d = pump_dir(mode_q, above_band);
                            end
                        end
                        EQ2: begin
                            cnt_en = 1'b1;
                            if (at_far) begin
                                pump_d = 2'b00;
                                st_d   = FAR_OPEN;
                            end else pump_d = pump_dir(mode_q, above_band);
                        end
                        FAR_OPEN: begin
                            if (!far_closed) begin
                                cnt_en = 1'b1;
                                if (cnt_q == DWELL_LAST) st_d = FAR_CLOSE;
                            end else cnt_zero = 1'b1;
                        end
                        FAR_CLOSE: begin
                            if (far_closed) begin
                                if (!mode_q) begin
                                    st_d   = RESTORE;
                                    pump_d = pump_dir(1'b1, above_band);
                                end else begin
                                    done_d = 1'b1;
                                    busy_d = 1'b0;
                                    st_d   = IDLE;
                                end
                            end
                        end
                        RESTORE: begin
                            cnt_en = 1'b1;
                            if (is_high) begin
                                pump_d = 2'b00;
                                done_d = ~aborted_q;
                                busy_d = 1'b0;
                                st_d   = IDLE;
                            end else pump_d = pump_dir(1'b1, above_band);
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        if (st_d != st_q || reenter || cnt_zero) cnt_d = '0;
        else if (cnt_en && cnt_q != CNT_MAX)      cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q                <= IDLE;
            mode_q              <= 1'b0;
            cnt_q               <= '0;
            aborted_q           <= 1'b0;
            pend_q              <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            fault               <= 1'b0;
            startPressurizing   <= 1'b0;
            startDepressurizing <= 1'b0;
        end else begin
            st_q                <= st_d;
            mode_q              <= mode_d;
            cnt_q               <= cnt_d;
            aborted_q           <= aborted_d;
            pend_q              <= pend_d;
            busy                <= busy_d;
            done                <= done_d;
            fault               <= fault_d;
            startPressurizing   <= pump_d[1];
            startDepressurizing <= pump_d[0];
        end
    end
endmodule

// File: doc/airlock_cycle_ctrl.md
Name: airlock_cycle_ctrl

Overview:
- Parametrised successor to the departure-only airlock FSM. Runs either a departure cycle (inner door, then outer door) or an arrival cycle (outer door, then inner door), selected per request.
- Adds a configurable pressure width and thresholds, a door-open dwell counter, an equalisation timeout with fault reporting, and abort.
- Sits between the door sensors, pressure sensor and pump controller, alongside the existing interlock logic.

Parameters:
- PW, 8: pressure bus width.
- P_LOW, 10: vacuum threshold; isLow = pressure < P_LOW.
- P_HI_MIN, 90: lower bound of the exclusive high band.
- P_HI_MAX, 110: upper bound of the exclusive high band; isHigh = P_HI_MIN < pressure < P_HI_MAX.
- DWELL, 5: consecutive cycles the near/far door must read open before a close is accepted.
- TIMEOUT, 1024: maximum cycles in any pump state before fault.
- CW, 11: counter width; must satisfy 2^CW > max(TIMEOUT, DWELL).

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: cycle request; sampled only in IDLE.
- mode, input, 1: 0 = departure, 1 = arrival; latched on accepted start.
- abort, input, 1: abort request, level sampled.
- odClosed, input, 1: outer door closed.
- idClosed, input, 1: inner door closed.
- pressure, input, PW: chamber pressure, unsigned.
- busy, output, 1: cycle in progress (includes FAULT).
- done, output, 1: one-cycle pulse on normal completion.
- fault, output, 1: timeout occurred; held until cleared.
- startPressurizing, output, 1: pump in.
- startDepressurizing, output, 1: pump out.
- state, output, 4: current state encoding, for debug.

Behaviour:
- Reset (reset=0, async): every output 0, state=IDLE, counters 0, mode latch 0. Takes effect immediately mid-cycle; both pumps drop in the same instant.
- Near door: inner if departure, outer if arrival. Far door is the other. Near target: high band if departure, low if arrival. Far target: the opposite.
- All outputs are registered; a transition and its output change appear on the same clock edge.
- IDLE: on start, busy<=1, latch mode, go to PREP. start while busy is ignored. No request queueing.
- PREP: wait for both doors closed. Then if pressure is already at the near target, go to NEAR_OPEN; else go to EQ1 and assert the pump direction.
- Pump direction to high: depress if pressure >= P_HI_MAX, else press. To low: always depress. Both pump outputs are never 1 together.
- EQ1: at near target, pumps<=0, go to NEAR_OPEN.
- NEAR_OPEN: count consecutive cycles with the near door open. Count clears whenever the door reads closed. Count reaching DWELL goes to NEAR_CLOSE.
- NEAR_CLOSE: near door closed -> EQ2 with the pump direction toward the far target.
- EQ2: at far target, pumps<=0, go to FAR_OPEN.
- FAR_OPEN / FAR_CLOSE: same dwell and close rules as NEAR, applied to the far door.
- FAR_CLOSE exit:
  - Departure: go to RESTORE and pump toward high.
  - Arrival: chamber is already high, so done<=1, busy<=0, go to IDLE.
- RESTORE: at high, pumps<=0, done<=1 for one cycle, busy<=0, go to IDLE.
- Timeout: the cycle counter clears on every state entry. In EQ1, EQ2 or RESTORE, reaching TIMEOUT cycles does the following: pumps<=0, fault<=1, go to FAULT. busy stays 1.
- FAULT: no pumping. abort=1 with both doors closed -> fault<=0, busy<=0, go to IDLE with no done pulse. start is ignored in FAULT.
- Abort in PREP, EQ1, EQ2 or RESTORE with both doors closed: pumps<=0, then enter RESTORE to bring the chamber to high. Completion from an aborted cycle returns to IDLE without a done pulse (tracked by an aborted flag).
- Abort while any door is open: held pending. It is taken at the first cycle both doors read closed, overriding the normal transition that cycle.
- Abort in IDLE: no effect.
- Simultaneous timeout and abort in the same cycle: timeout wins (go to FAULT).
- Counters saturate and never wrap.

Test Plan:
- Departure, pressure=50, doors closed, start: press asserted next edge. Ramp pressure to 100 -> NEAR_OPEN. Inner door open 5 cycles then closed -> depress on. Pressure 5 -> FAR_OPEN. Outer door open 5, closed -> press. Pressure 100 -> done pulse for exactly 1 cycle, busy=0.
- Arrival, pressure=100: start -> depress until 5. Outer door open/closed -> press until 100. Inner door open/closed -> done with no RESTORE state visited.
- Dwell: open near door 3 cycles, close, reopen 5 cycles -> NEAR_CLOSE entered only after the second run of 5.
- Timeout (TIMEOUT=16): hold pressure=50 in EQ1 -> at cycle 16 pumps=0, fault=1, busy=1. Abort with doors closed -> IDLE, fault=0, no done.
- Abort with inner door open in NEAR_OPEN: no change. Close door -> RESTORE, pump toward high, IDLE with done=0.
- Assert reset low mid-EQ2 with depress=1 -> all outputs 0 immediately, before the next edge. Release, start accepted normally.
